// File: rtl/video_frame_sink.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_sink
//  Description : Sink for the 24-bit RGB valid/ready video stream and its
//                36-bit control packet. It latches the frame geometry and
//                accepts pixels while tracking the raster position. It pulses
//                frame_done at each frame end and keeps sticky error flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_DIM           largest legal width/height in a control packet
//    CNT_W             width of the x/y counters and the frame counter
//  Optional feature
//    FRAME_CHECKSUM_EN adds output frame_sum[23:0], which is the modulo-2^24
//                      sum of the pixels accepted in the last completed frame
//  Ports
//    clk               system clock
//    rst               asynchronous active-high reset
//    control_in_data   {width[35:20], height[19:4], 4'h0}
//    control_in_valid  1-cycle strobe qualifying control_in_data
//    video_in_data     pixel {R,G,B}
//    video_in_valid    pixel present
//    video_in_ready    pixel accepted this cycle (when valid)
//    sink_en           0 forces video_in_ready low (backpressure)
//    frame_done        1-cycle pulse after the last pixel of a frame
//    frame_count       frames completed since reset (wrapping)
//    pix_x, pix_y      raster position of the next expected pixel
//    size_err          sticky: control packet arrived mid-frame
//    ctrl_err          sticky: control packet with illegal dimension
//    orphan_err        sticky: pixel offered while idle
// ============================================================================
module video_frame_sink #(
    parameter int MAX_DIM = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [35:0]      control_in_data,
    input  logic             control_in_valid,
    input  logic [23:0]      video_in_data,
    input  logic             video_in_valid,
    output logic             video_in_ready,
    input  logic             sink_en,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             size_err,
    output logic             ctrl_err,
    output logic             orphan_err
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [23:0]      frame_sum
`endif
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [15:0]      c_max_dim = 16'(MAX_DIM);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero    = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] height_q, height_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             frame_done_q, frame_done_d;
    logic             size_err_q, size_err_d;
    logic             ctrl_err_q, ctrl_err_d;
    logic             orphan_err_q, orphan_err_d;
`ifdef FRAME_CHECKSUM_EN
    logic [23:0]      acc_q, acc_d;
    logic [23:0]      sum_q, sum_d;
`endif

    logic [15:0] w_ctrl_w;
    logic [15:0] w_ctrl_h;
    logic        w_ctrl_legal;
    logic        w_accept;
    logic        w_last_x;
    logic        w_last_y;
    logic        w_frame_last;
    logic        w_at_origin;
    logic        w_unused_ctrl_bits;

    assign w_ctrl_w           = control_in_data[35:20];
    assign w_ctrl_h           = control_in_data[19:4];
    assign w_unused_ctrl_bits = ^control_in_data[3:0];
    assign w_ctrl_legal       = (w_ctrl_w != 16'd0) && (w_ctrl_h != 16'd0) &&
                                (w_ctrl_w <= c_max_dim) && (w_ctrl_h <= c_max_dim);

    assign video_in_ready = (state_q == S_ACTIVE) && sink_en;
    assign w_accept       = video_in_valid && video_in_ready;
    assign w_last_x       = (x_q == (width_q - c_one));
    assign w_last_y       = (y_q == (height_q - c_one));
    assign w_frame_last   = w_accept && w_last_x && w_last_y;
    // A frame that completes in this same cycle puts the raster back at the
    // origin, so a control packet that arrives with it is not a mid-frame one.
    assign w_at_origin    = ((x_q == c_zero) && (y_q == c_zero)) || w_frame_last;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        x_d          = x_q;
        y_d          = y_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        size_err_d   = size_err_q;
        ctrl_err_d   = ctrl_err_q;
        orphan_err_d = orphan_err_q;
`ifdef FRAME_CHECKSUM_EN
        acc_d        = acc_q;
        sum_d        = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (control_in_valid) begin
                    if (w_ctrl_legal) begin
                        width_d  = CNT_W'(w_ctrl_w);
                        height_d = CNT_W'(w_ctrl_h);
                        x_d      = c_zero;
                        y_d      = c_zero;
                        state_d  = S_ACTIVE;
`ifdef FRAME_CHECKSUM_EN
                        acc_d    = 24'd0;
`endif
                    end else begin
                        ctrl_err_d = 1'b1;
                    end
                end
                if (video_in_valid) begin
                    orphan_err_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_accept) begin
`ifdef FRAME_CHECKSUM_EN
                    acc_d = acc_q + video_in_data;
`endif
                    if (w_last_x) begin
                        x_d = c_zero;
                        if (w_last_y) begin
                            y_d          = c_zero;
                            frame_done_d = 1'b1;
                            count_d      = count_q + c_one;
`ifdef FRAME_CHECKSUM_EN
                            sum_d        = acc_q + video_in_data;
                            acc_d        = 24'd0;
`endif
                        end else begin
                            y_d = y_q + c_one;
                        end
                    end else begin
                        x_d = x_q + c_one;
                    end
                end
                // Control overrides the pixel counting done above: a pixel
                // accepted alongside a relatch is not counted into the new frame.
                if (control_in_valid) begin
                    if (!w_at_origin) begin
                        size_err_d = 1'b1;
                    end
                    x_d = c_zero;
                    y_d = c_zero;
`ifdef FRAME_CHECKSUM_EN
                    acc_d = 24'd0;
`endif
                    if (w_ctrl_legal) begin
                        width_d  = CNT_W'(w_ctrl_w);
                        height_d = CNT_W'(w_ctrl_h);
                    end else begin
                        ctrl_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            size_err_q   <= 1'b0;
            ctrl_err_q   <= 1'b0;
            orphan_err_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            acc_q        <= '0;
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            x_q          <= x_d;
            y_q          <= y_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            size_err_q   <= size_err_d;
            ctrl_err_q   <= ctrl_err_d;
            orphan_err_q <= orphan_err_d;
`ifdef FRAME_CHECKSUM_EN
            acc_q        <= acc_d;
            sum_q        <= sum_d;
`endif
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = count_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign size_err    = size_err_q;
    assign ctrl_err    = ctrl_err_q;
    assign orphan_err  = orphan_err_q;
`ifdef FRAME_CHECKSUM_EN
    assign frame_sum   = sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_frame_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_frame_sink
//  Description : Self-checking bench for video_frame_sink. A frame-level
//                reference model predicts the sink behaviour. Predicted frame
//                completions go into a scoreboard queue, and an independent
//                monitor drains that queue against frame_done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_frame_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [35:0] control_in_data = '0;
    logic        control_in_valid = 1'b0;
    logic [23:0] video_in_data = '0;
    logic        video_in_valid = 1'b0;
    logic        video_in_ready;
    logic        sink_en = 1'b0;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        size_err;
    logic        ctrl_err;
    logic        orphan_err;
`ifdef FRAME_CHECKSUM_EN
    logic [23:0] frame_sum;
`endif

    video_frame_sink #(.MAX_DIM(4096), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .control_in_data  (control_in_data),
        .control_in_valid (control_in_valid),
        .video_in_data    (video_in_data),
        .video_in_valid   (video_in_valid),
        .video_in_ready   (video_in_ready),
        .sink_en          (sink_en),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .size_err         (size_err),
        .ctrl_err         (ctrl_err),
        .orphan_err       (orphan_err)
`ifdef FRAME_CHECKSUM_EN
        ,
        .frame_sum        (frame_sum)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned edge_cnt    = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard entry: the clock edge after which frame_done must be high,
    // and the frame_count that must be shown with it.
    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
    } done_t;
    done_t exp_q[$];

    // Reference model: position is a pixel index within the frame.
    bit          m_active;
    int unsigned m_w, m_h, m_n, m_count;
    bit          m_size, m_ctrl, m_orph;
    int unsigned m_acc, m_sum;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_w = 0; m_h = 0; m_n = 0; m_count = 0;
        m_size = 0; m_ctrl = 0; m_orph = 0; m_acc = 0; m_sum = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit cv, input int unsigned cw, input int unsigned ch,
                                       input bit vv, input int unsigned vd, input bit se);
        bit          legal = (cw != 0) && (ch != 0) && (cw <= 4096) && (ch <= 4096);
        bit          done  = 0;
        int unsigned n0    = m_n;
        done_t       e;
        if (!m_active) begin
            if (cv) begin
                if (legal) begin
                    m_w = cw; m_h = ch; m_n = 0; m_acc = 0; m_active = 1;
                end else begin
                    m_ctrl = 1;
                end
            end
            if (vv) m_orph = 1;
        end else begin
            if (vv && se) begin
                m_acc = (m_acc + vd) % (1 << 24);
                m_n++;
                if (m_n == m_w * m_h) begin
                    done    = 1;
                    m_n     = 0;
                    m_count = (m_count + 1) % 65536;
                    m_sum   = m_acc;
                    m_acc   = 0;
                    e.cyc   = edge_cnt + 1;
                    e.cnt   = m_count;
                    exp_q.push_back(e);
                end
            end
            if (cv) begin
                if (!(n0 == 0 || done)) m_size = 1;
                m_n = 0; m_acc = 0;
                if (legal) begin
                    m_w = cw; m_h = ch;
                end else begin
                    m_ctrl = 1; m_active = 0;
                end
            end
        end
    endfunction

    task automatic check_state();
        chk("pix_x", pix_x, (m_w == 0) ? 0 : m_n % m_w);
        chk("pix_y", pix_y, (m_w == 0) ? 0 : m_n / m_w);
        chk("frame_count", frame_count, m_count);
        chk("size_err", size_err, m_size);
        chk("ctrl_err", ctrl_err, m_ctrl);
        chk("orphan_err", orphan_err, m_orph);
`ifdef FRAME_CHECKSUM_EN
        chk("frame_sum", frame_sum, m_sum);
`endif
    endtask

    // One clock cycle of stimulus: entered and left at a falling edge.
    task automatic step(input bit cv, input int unsigned cw, input int unsigned ch,
                        input bit vv, input int unsigned vd, input bit se);
        control_in_valid = cv;
        control_in_data  = {cw[15:0], ch[15:0], 4'h0};
        video_in_valid   = vv;
        video_in_data    = vd[23:0];
        sink_en          = se;
        #1;
        chk("video_in_ready", video_in_ready, m_active && se);
        model_step(cv, cw, ch, vv, vd, se);
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    // Reset is raised between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        control_in_valid = 1'b0;
        video_in_valid   = 1'b0;
        #1;
        chk("rst_ready", video_in_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_errors", {size_err, ctrl_err, orphan_err}, 0);
`ifdef FRAME_CHECKSUM_EN
        chk("rst_frame_sum", frame_sum, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: each predicted completion must show up as a
    // frame_done pulse on exactly its cycle, and no other pulse is allowed.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
                chk("frame_done_pulse", frame_done, 1);
                chk("frame_done_count", frame_count, exp_q[0].cnt);
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                chk("frame_done_stale", exp_q[0].cyc, edge_cnt);
                void'(exp_q.pop_front());
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Pixels offered before any control packet are orphans.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, $urandom, 1);
        do_reset();

        // Full 160x36 frame at full throughput, then a few idle beats.
        step(1, 160, 36, 0, 0, 1);
        for (int i = 0; i < 5760; i++) step(0, 0, 0, 1, $urandom, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        chk("t1_count", frame_count, 1);

        // 4x2 frame with sink_en toggling every cycle.
        do_reset();
        step(1, 4, 2, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, $urandom, (i % 2) == 0);
        chk("t2_count", frame_count, 1);

        // Relatch to 2x2 after three beats of a 4x2 frame.
        step(1, 4, 2, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom, 1);
        step(1, 2, 2, 0, 0, 1);
        chk("t4_size_err", size_err, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, (i < 4), $urandom, 1);
        chk("t4_count", frame_count, 2);

        // Illegal geometries while idle.
        do_reset();
        step(1, 0, 10, 0, 0, 1);
        chk("t5_ctrl_err_zero", ctrl_err, 1);
        do_reset();
        step(1, 5000, 5, 0, 0, 1);
        chk("t5_ctrl_err_big", ctrl_err, 1);
        step(1, 4096, 4096, 0, 0, 1);
        step(0, 0, 0, 1, $urandom, 1);

        // Checksum wrap: 0xFFFFFF + 2 over a 2x1 frame.
        do_reset();
        step(1, 2, 1, 0, 0, 1);
        step(0, 0, 0, 1, 24'hFFFFFF, 1);
        step(0, 0, 0, 1, 2, 1);
`ifdef FRAME_CHECKSUM_EN
        chk("t6_frame_sum", frame_sum, 24'h000001);
`endif

        // Mid-frame reset.
        step(1, 3, 3, 0, 0, 1);
        step(0, 0, 0, 1, $urandom, 1);
        step(0, 0, 0, 1, $urandom, 1);
        do_reset();

        // Randomized traffic with occasional control packets and resets.
        for (int i = 0; i < 4000; i++) begin
            bit          cv = ($urandom_range(0, 29) == 0);
            int unsigned r  = $urandom_range(0, 9);
            int unsigned cw = (r == 0) ? 0 : (r == 1) ? $urandom_range(4097, 65535) :
                              (r == 2) ? 4096 : $urandom_range(1, 5);
            int unsigned ch = (r == 3) ? 0 : $urandom_range(1, 4);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step(cv, cw, ch, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
            end
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
